// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
// Holds the FSM state type, default width constants and the round-robin pick function.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int MAX_REQ       = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 8;
  localparam int BURST_W       = $clog2(DEF_MAX_BURST + 1);
  localparam int OWNER_W       = $clog2(DEF_NUM_REQ);

  // Search starts just after last_owner and wraps; the nearest requester wins.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                 input int num_req,
                                 input int last_owner);
    int idx;
    int pick;
    pick = last_owner;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= num_req) begin
        idx = (last_owner + i) % num_req;
        if (req[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_occupancy_ctr.sv
// Occupancy counter for the shared FIFO; full/empty decode straight from the count
// so the flags can never lag it.
module fifo_occupancy_ctr #(
  parameter int FIFO_DEPTH = 520,
  parameter int PTR_WIDTH  = 10
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 accept,
  input  logic                 pop,
  output logic [PTR_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [PTR_WIDTH-1:0] DEPTH = PTR_WIDTH'(FIFO_DEPTH);

  logic [PTR_WIDTH-1:0] count_reg;

  // Callers gate accept with !full and pop with !empty, so no saturation is needed here.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      count_reg <= '0;
    end else if (accept && !pop) begin
      count_reg <= count_reg + 1'b1;
    end else if (pop && !accept) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign full  = (count_reg == DEPTH);
  assign empty = (count_reg == '0);

endmodule

// File: rtl/fifo_write_arbiter_non2n.sv
// Round-robin, burst-bounded write arbiter in front of a non-power-of-2 FIFO.
// Optional macro FIFO_ARB_WATERMARK_EN adds almost_full and throttles new grants on it.
module fifo_write_arbiter_non2n
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 520,
  parameter int PTR_WIDTH  = 10,
  parameter int MAX_BURST  = 8
`ifdef FIFO_ARB_WATERMARK_EN
  ,
  parameter int WATERMARK  = 16
`endif
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          r_en,
  output logic [PTR_WIDTH-1:0]          count,
  output logic                          full,
  output logic                          empty,
`ifdef FIFO_ARB_WATERMARK_EN
  output logic                          almost_full,
`endif
  output logic                          busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  arb_state_t             state_reg;
  logic [OW-1:0]          owner_reg;
  logic [BW-1:0]          burst_cnt_reg;
  logic [NUM_REQ-1:0]     gnt_reg;
  logic                   w_en_reg;
  logic [DATA_WIDTH-1:0]  wdata_reg;

  logic [DATA_WIDTH-1:0]  beat [NUM_REQ];
  logic [MAX_REQ-1:0]     req_ext;
  logic [OW-1:0]          winner;
  logic                   accept;
  logic                   pop;
  logic                   grant_ok;
  logic                   owner_req;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_beat
      assign beat[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
  end

  assign winner    = OW'(rr_pick(req_ext, NUM_REQ, int'(owner_reg)));
  assign owner_req = req[owner_reg];
  assign accept    = (|(gnt_reg & req)) && !full;
  assign pop       = r_en && !empty;

`ifdef FIFO_ARB_WATERMARK_EN
  localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(FIFO_DEPTH - WATERMARK);
  assign almost_full = (count >= AF_LEVEL);
  assign grant_ok    = (|req) && !full && !almost_full;
`else
  assign grant_ok    = (|req) && !full;
`endif

  fifo_occupancy_ctr #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_occ (
    .wclk   (wclk),
    .wrst   (wrst),
    .accept (accept),
    .pop    (pop),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // A stalled burst (full, owner still requesting) keeps its grant until space frees up.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_reg     <= IDLE;
      owner_reg     <= OW'(NUM_REQ - 1);
      burst_cnt_reg <= '0;
      gnt_reg       <= '0;
      w_en_reg      <= 1'b0;
      wdata_reg     <= '0;
    end else begin
      w_en_reg <= accept;
      if (accept) wdata_reg <= beat[owner_reg];
      case (state_reg)
        IDLE: begin
          if (grant_ok) begin
            gnt_reg       <= NUM_REQ'(1) << winner;
            owner_reg     <= winner;
            burst_cnt_reg <= '0;
            state_reg     <= BURST;
          end
        end
        BURST: begin
          if (!owner_req) begin
            gnt_reg   <= '0;
            state_reg <= IDLE;
          end else if (accept) begin
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
            if (burst_cnt_reg == LAST_BEAT) begin
              gnt_reg   <= '0;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_reg;
  assign fifo_w_en  = w_en_reg;
  assign fifo_wdata = wdata_reg;
  assign busy       = (state_reg == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter_non2n.sv
// Directed bench for fifo_write_arbiter_non2n: requester models stream tagged beats,
// a scoreboard queue holds the beats expected at the FIFO write port.
module tb_fifo_write_arbiter_non2n;

  logic        wclk = 1'b0;
  logic        wrst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_w_en;
  logic [7:0]  fifo_wdata;
  logic        r_en = 1'b0;
  logic [9:0]  count;
  logic        full;
  logic        empty;
  logic        busy;
`ifdef FIFO_ARB_WATERMARK_EN
  logic        almost_full;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;
  bit          sb_en = 1'b0;
  int          sent_cnt[4];

  fifo_write_arbiter_non2n dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .fifo_w_en   (fifo_w_en),
    .fifo_wdata  (fifo_wdata),
    .r_en        (r_en),
    .count       (count),
    .full        (full),
    .empty       (empty),
`ifdef FIFO_ARB_WATERMARK_EN
    .almost_full (almost_full),
`endif
    .busy        (busy)
  );

  always #5 wclk = ~wclk;

  // Requester i presents beat {i, sequence}; it advances once its beat is taken.
  always_comb begin
    req_data = '0;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'((i << 5) | (sent_cnt[i] & 31));
  end

  always @(posedge wclk) begin
    for (int i = 0; i < 4; i++) begin
      if (wrst) sent_cnt[i] <= 0;
      else if (gnt[i] && req[i] && !full) sent_cnt[i] <= sent_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_beats(input int who, input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(8'((who << 5) | ((first + k) & 31)));
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    req  = '0;
    r_en = 1'b0;
    tick();
    wrst = 1'b0;
  endtask

  always @(negedge wclk) begin
    if (sb_en && fifo_w_en === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed write %02h expected none", fifo_wdata);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        $display("write: data=%02h expected=%02h count=%0d", fifo_wdata, mon_exp, count);
        check("sb_data", 32'(fifo_wdata), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish within 20000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for two cycles
    wrst = 1'b1;
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_gnt", gnt, 0);
    check("rst_wen", fifo_w_en, 0);
    check("rst_busy", busy, 0);
    wrst = 1'b0;
    tick();
    check("idle_gnt", gnt, 0);

    // Single requester: two 8-beat bursts with one idle cycle between
    push_beats(0, 0, 16);
    sb_en = 1'b1;
    req = 4'b0001;
    tick();
    check("s2_gnt_first", gnt, 4'b0001);
    check("s2_busy", busy, 1);
    check("s2_count0", count, 0);
    tick();
    check("s2_wen_first", fifo_w_en, 1);
    check("s2_count1", count, 1);
    repeat (7) tick();
    check("s2_gnt_gap", gnt, 0);
    check("s2_count8", count, 8);
    check("s2_wen_last", fifo_w_en, 1);
    tick();
    check("s2_regrant", gnt, 4'b0001);
    check("s2_wen_gap", fifo_w_en, 0);
    repeat (8) tick();
    check("s2_count16", count, 16);
    check("s2_gnt_end", gnt, 0);
    req = '0;
    tick();
    tick();
    check("s2_sb_drain", exp_q.size(), 0);
    sb_en = 1'b0;

    // All requesting: owners rotate 0,1,2,3,0
    do_reset();
    push_beats(0, 0, 8);
    push_beats(1, 0, 8);
    push_beats(2, 0, 8);
    push_beats(3, 0, 8);
    push_beats(0, 8, 8);
    sb_en = 1'b1;
    req = 4'b1111;
    tick();
    check("s3_owner0", gnt, 4'b0001);
    for (int b = 1; b < 5; b++) begin
      repeat (9) tick();
      check("s3_owner", gnt, 32'(1 << (b % 4)));
    end
    repeat (8) tick();
    check("s3_gnt_end", gnt, 0);
    check("s3_count40", count, 40);
    req = '0;
    tick();
    tick();
    check("s3_sb_drain", exp_q.size(), 0);
    sb_en = 1'b0;

`ifndef FIFO_ARB_WATERMARK_EN
    // Fill to capacity mid-burst, stall, pop one, resume
    do_reset();
    req = 4'b0001;
    for (int n = 0; n < 2000 && count != 10'd515; n++) tick();
    check("s4_preload", count, 515);
    req = '0;
    tick();
    check("s4_idle", gnt, 0);
    push_beats(1, 0, 6);
    sb_en = 1'b1;
    req = 4'b0010;
    tick();
    check("s4_gnt", gnt, 4'b0010);
    repeat (4) tick();
    check("s4_count519", count, 519);
    check("s4_notfull", full, 0);
    tick();
    check("s4_count520", count, 520);
    check("s4_full", full, 1);
    tick();
    check("s4_stall_wen", fifo_w_en, 0);
    check("s4_stall_gnt", gnt, 4'b0010);
    check("s4_stall_count", count, 520);
    check("s4_stall_busy", busy, 1);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    check("s4_pop_count", count, 519);
    check("s4_pop_full", full, 0);
    check("s4_pop_wen", fifo_w_en, 0);
    tick();
    check("s4_refill_count", count, 520);
    check("s4_refill_full", full, 1);
    check("s4_refill_wen", fifo_w_en, 1);
    req = '0;
    tick();
    tick();
    check("s4_sb_drain", exp_q.size(), 0);
    sb_en = 1'b0;
`endif

    // Simultaneous accept and pop, then pop on empty
    do_reset();
    req = 4'b0001;
    repeat (6) tick();
    check("s5_count5", count, 5);
    r_en = 1'b1;
    tick();
    check("s5_both_count", count, 5);
    check("s5_both_wen", fifo_w_en, 1);
    req = '0;
    repeat (5) tick();
    check("s5_drained", count, 0);
    tick();
    check("s5_empty_pop_count", count, 0);
    check("s5_empty_flag", empty, 1);
    r_en = 1'b0;

    // Reset in the middle of a burst
    do_reset();
    req = 4'b0001;
    repeat (4) tick();
    check("s6_count3", count, 3);
    wrst = 1'b1;
    tick();
    check("s6_gnt", gnt, 0);
    check("s6_count", count, 0);
    check("s6_wen", fifo_w_en, 0);
    check("s6_busy", busy, 0);
    check("s6_empty", empty, 1);
    wrst = 1'b0;
    req = 4'b1111;
    tick();
    check("s6_first_owner", gnt, 4'b0001);
    req = '0;
    tick();

    // IDLE at count 504 with requester 1 asking
    do_reset();
    req = 4'b0001;
    for (int n = 0; n < 2000 && count != 10'd504; n++) tick();
    check("s7_preload", count, 504);
    req = 4'b0010;
    tick();
`ifdef FIFO_ARB_WATERMARK_EN
    check("s7_almost_full", almost_full, 1);
    check("s7_no_grant", gnt, 0);
    tick();
    check("s7_still_no_grant", gnt, 0);
`else
    check("s7_grant", gnt, 4'b0010);
    check("s7_busy", busy, 1);
`endif
    req = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
